pipe_elastic_reg: RTL and testbench
===================================

Name: pipe_elastic_reg

Overview:
- Parametrised elastic pipeline register: the successor to the fixed IF/ID latch.
- Carries a WIDTH-bit payload (e.g. {PC, instruction}) between two CPU pipeline stages through a DEPTH-entry circular buffer.
- Interface: valid/ready handshake on both sides, plus a hold (stall) input and a flush input.
- Empty output presents a configurable bubble word (e.g. NOP), so downstream decode needs no special-casing.

Parameters:
WIDTH, 64, payload width in bits (1..256)
DEPTH, 2, buffer entries (1..16, need not be a power of two); DEPTH>=2 required for full throughput
BUBBLE, {WIDTH{1'b0}}, value driven on out_data when empty (e.g. 64'h0000_0000_0000_0013 = PC 0 + RV32 NOP)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries (branch/jump taken)
hold  input  1  1 = freeze output side (data hazard); no dequeue
in_valid  input  1  upstream offers in_data
in_ready  output  1  buffer can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  buffer non-empty
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  head entry, or BUBBLE when empty
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, wr_ptr=rd_ptr=0, out_valid=0, in_ready=1, out_data=BUBBLE. Buffer contents are don't-care and not cleared. Reset mid-transfer drops all entries.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~hold & ~flush.
- in_ready = (count != DEPTH); it depends only on registered state.
- No combinational path from out_ready or hold to in_ready. No full-buffer bypass: when full, in_ready=0 even if a pop occurs that cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, else BUBBLE. The mux reads only registers.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N (one cycle).
- Ordering: strict FIFO.
- Push: writes mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments, wrapping DEPTH-1 -> 0.
- count update: push only +1; pop only -1; push and pop together: count unchanged, both pointers advance.
- Empty with in_valid=1: no same-cycle pass-through; data appears next cycle.
- hold=1:
  - out_valid/out_data stay stable.
  - Pushes are still accepted while not full, so upstream continues until full.
  - hold together with out_ready=1 causes no pop.
- flush=1 (priority over push, pop and hold): at the edge, count=0 and wr_ptr=rd_ptr=0. The incoming in_data that cycle is discarded. out_data=BUBBLE the next cycle.
- DEPTH=1: behaves as a single register with registered ready, giving half throughput (accept, drain, accept).
- No error states: overflow and underflow are impossible by construction.
- Per the handshake rule, in_data/in_valid must be held until accepted. A change while in_valid=1 & in_ready=0 is tolerated and not flagged.

Optional Feature:
- Macro PIPE_ELASTIC_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cnt[31:0]: increments every cycle with out_valid & (hold | ~out_ready).
  - flush_cnt[31:0]: increments on every flush where count != 0.
- Both counters saturate at 32'hFFFF_FFFF, are cleared by rst_n only (not by flush), and are readable the cycle after the event.
- When not defined: ports and logic are absent; the core behaviour above is identical.

Test Plan:
- Reset: rst_n=0 mid-stream with count=2 -> immediately out_valid=0, count=0, out_data=BUBBLE, in_ready=1.
- Streaming, DEPTH=2, out_ready=1, hold=0: push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 in order, one cycle later each, no gaps, count stays 1.
- Fill/full (ordering, pointer wrap):
  - Step 1: out_ready=0, push 0xA, 0xB -> count=2, in_ready=0, third word 0xC not accepted.
  - Step 2: out_ready=1 -> 0xA, 0xB, then 0xC exit.
  - Step 3: repeat 5 times for wrap coverage with DEPTH=3.
- hold: count=1 head 0x55, hold=1 for 3 cycles with out_ready=1 -> out_data stays 0x55, no pop; concurrent push 0x66 accepted (count=2). Release hold -> 0x55 then 0x66.
- flush: count=2, flush=1 with in_valid=1 data 0x77 -> next cycle count=0, out_valid=0, out_data=BUBBLE, 0x77 never emerges. With the macro: flush_cnt=1.
- DEPTH=1 and counters (macro on): continuous in_valid -> in_ready toggles 1,0,1,0, throughput 1/2. Hold out_ready=0 for 4 cycles with a valid head -> stall_cnt=4.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: elastic register between two CPU pipeline stages.
// A DEPTH-entry circular buffer with valid/ready on both sides, a hold
// input that freezes the output side and a flush input that empties
// the buffer. When empty, out_data shows the BUBBLE word so decode can
// treat an empty slot as an ordinary (NOP) instruction.
//
// Optional build macro PIPE_ELASTIC_PERF_CNT_EN adds the saturating
// stall_cnt / flush_cnt outputs. These counters are cleared only by rst_n.
module pipe_elastic_reg #(
    parameter int               WIDTH  = 64,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_ELASTIC_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A one-entry buffer still needs a 1-bit pointer to keep the
    // declarations legal. In that case the pointer stays at zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Storage has no reset. Only occupancy and pointers decide which
    // entries are meaningful.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Pointer advance wraps at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshake status is derived from registered occupancy only. A pop in
    // the same cycle therefore never frees a slot for a push into a full buffer.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~hold & ~flush;
    end

    // The output mux reads registers only. An empty buffer presents the bubble word.
    always_comb begin
        out_data = BUBBLE;
        if (out_valid) begin
            out_data = mem_q[rd_ptr_q];
        end
        count = count_q;
    end

    // Next-state logic for pointers and occupancy. Flush wins over everything else.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers. The asynchronous reset drops every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload write on an accepted push. Flush suppresses push, so the
    // word offered during a flush is never stored.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef PIPE_ELASTIC_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters. A stall is a valid head that is not
    // taken because of hold or backpressure. A flush event is counted
    // only when the flush discards something.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && (hold || !out_ready) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (count_q != '0) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers are cleared by rst_n only. Flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Testbench for pipe_elastic_reg. Three instances (DEPTH 1, 2 and 3) share
// one input stimulus. Each instance is compared every cycle against its own
// occupancy/FIFO reference model, which is kept as a 16-slot ring of words.
module tb_pipe_elastic_reg;

    localparam int               W   = 16;
    localparam logic [W-1:0]     BUB = 16'h0013;
    localparam int               DEP [3] = '{1, 2, 3};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         hold;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         ir [3];
    logic         ov [3];
    logic [W-1:0] od [3];
    logic [0:0]   c1;
    logic [1:0]   c2;
    logic [1:0]   c3;
`ifdef PIPE_ELASTIC_PERF_CNT_EN
    logic [31:0]  sc [3];
    logic [31:0]  fc [3];
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered word list per instance, plus event counts.
    logic [W-1:0] mm [3][16];
    int           hd [3];
    int           sz [3];
    int           ms [3];
    int           mf [3];

    always #5 clk = ~clk;

    pipe_elastic_reg #(.WIDTH(W), .DEPTH(1), .BUBBLE(BUB)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .count(c1)
`ifdef PIPE_ELASTIC_PERF_CNT_EN
        , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
    );

    pipe_elastic_reg #(.WIDTH(W), .DEPTH(2), .BUBBLE(BUB)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .count(c2)
`ifdef PIPE_ELASTIC_PERF_CNT_EN
        , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
    );

    pipe_elastic_reg #(.WIDTH(W), .DEPTH(3), .BUBBLE(BUB)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .count(c3)
`ifdef PIPE_ELASTIC_PERF_CNT_EN
        , .stall_cnt(sc[2]), .flush_cnt(fc[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int k);
        case (k)
            0:       return 32'(c1);
            1:       return 32'(c2);
            default: return 32'(c3);
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            hd[k] = 0;
            sz[k] = 0;
            ms[k] = 0;
            mf[k] = 0;
        end
    endtask

    // Compares the visible state of every instance with the model.
    task automatic compare_all();
        logic [W-1:0] head;
        for (int k = 0; k < 3; k++) begin
            head = BUB;
            if (sz[k] != 0) head = mm[k][hd[k]];
            chk($sformatf("d%0d.count", DEP[k]), get_cnt(k), 32'(sz[k]));
            chk($sformatf("d%0d.out_valid", DEP[k]), 32'(ov[k]), 32'(sz[k] != 0));
            chk($sformatf("d%0d.in_ready", DEP[k]), 32'(ir[k]), 32'(sz[k] != DEP[k]));
            chk($sformatf("d%0d.out_data", DEP[k]), 32'(od[k]), 32'(head));
`ifdef PIPE_ELASTIC_PERF_CNT_EN
            chk($sformatf("d%0d.stall_cnt", DEP[k]), sc[k], 32'(ms[k]));
            chk($sformatf("d%0d.flush_cnt", DEP[k]), fc[k], 32'(mf[k]));
`endif
        end
    endtask

    // One clock: check at the falling edge, decide transfers from the model,
    // apply them at the rising edge, then return 1 time unit later.
    task automatic tick();
        logic         pu [3];
        logic         po [3];
        logic         st [3];
        logic         fe [3];
        logic [W-1:0] d;
        logic         fl;
        @(negedge clk);
        compare_all();
        d  = in_data;
        fl = flush;
        for (int k = 0; k < 3; k++) begin
            pu[k] = in_valid && (sz[k] != DEP[k]) && !flush;
            po[k] = (sz[k] != 0) && out_ready && !hold && !flush;
            st[k] = (sz[k] != 0) && (hold || !out_ready);
            fe[k] = flush && (sz[k] != 0);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (st[k]) ms[k]++;
            if (fe[k]) mf[k]++;
            if (fl) begin
                hd[k] = 0;
                sz[k] = 0;
            end else begin
                if (po[k]) begin
                    hd[k] = (hd[k] + 1) % 16;
                    sz[k]--;
                end
                if (pu[k]) begin
                    mm[k][(hd[k] + sz[k]) % 16] = d;
                    sz[k]++;
                end
            end
        end
        #1;
    endtask

    // Asserts the asynchronous reset mid-cycle and checks its immediate effect.
    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.d%0d.count", tag, DEP[k]), get_cnt(k), 32'd0);
            chk($sformatf("%s.d%0d.out_valid", tag, DEP[k]), 32'(ov[k]), 32'd0);
            chk($sformatf("%s.d%0d.in_ready", tag, DEP[k]), 32'(ir[k]), 32'd1);
            chk($sformatf("%s.d%0d.out_data", tag, DEP[k]), 32'(od[k]), 32'(BUB));
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        model_clear();
        async_reset_check("por");

        // Streaming: one word per cycle with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Fill to full, hold off, then drain. Repeating this wraps the pointers.
        for (int r = 0; r < 5; r++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'h000A; tick();
            in_data   = 16'h000B; tick();
            in_data   = 16'h000C; tick();
            tick();
            out_ready = 1'b1;
            repeat (3) tick();
            in_valid  = 1'b0;
            repeat (4) tick();
        end

        // Hold freezes the head while pushes continue.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0055; tick();
        in_valid  = 1'b0;     tick();
        hold      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0066; tick();
        in_valid  = 1'b0;
        repeat (2) tick();
        hold      = 1'b0;
        repeat (3) tick();

        // Flush with a word on the input discards everything.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0001; tick();
        in_data   = 16'h0002; tick();
        flush     = 1'b1;
        in_data   = 16'h0077; tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Valid head held under backpressure for 4 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0009; tick();
        in_valid  = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Reset mid-stream while the buffers are non-empty.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0021; tick();
        in_data   = 16'h0022; tick();
        in_valid  = 1'b0;
        async_reset_check("mid");
        repeat (2) tick();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            hold      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
